// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: EX->MEM pipeline register with a 2-entry skid buffer and a registered upstream ready.
// Ports:
//   clk_i, rst_i (async, active-low)   clock and reset
//   flush_i                            drop every held and incoming entry
//   in_valid_i / in_ready_o            upstream handshake (in_ready_o is a flop)
//   WB_i, M_i, ALU_i, wdata_i, rd_i    incoming EX results
//   out_valid_o / out_ready_i          downstream handshake
//   WB_o, M_o, ALU_o, wdata_o, rd_o    main slot contents
//   occ_o                              number of held entries, 0..2
module pipe_stage_skid #(
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [DATA_W-1:0] ALU_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [M_W-1:0]    M_o,
  output logic [DATA_W-1:0] ALU_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [1:0]        occ_o
);
  localparam int LW = 2 * DATA_W + REG_W;
  localparam int EW = WB_W + M_W + LW;
  logic [EW-1:0] in_ent, main_q, main_d, main_n, skid_q, skid_d;
  logic          main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q;
  logic [1:0]    occ_q, occ_d;
  logic          accept, drain, load_in, load_sk, load_skid;
  assign in_ent    = {WB_i, M_i, ALU_i, wdata_i, rd_i};
  assign accept    = in_valid_i & rdy_q;
  assign drain     = main_v_q & out_ready_i;
  assign load_in   = !flush_i & accept & (!main_v_q | drain);
  assign load_sk   = !flush_i & skid_v_q & drain;
  assign load_skid = !flush_i & accept & main_v_q & !drain;
  always_comb begin
    main_v_d = flush_i ? 1'b0 : skid_v_q ? 1'b1 : accept | (main_v_q & !drain);
    skid_v_d = flush_i ? 1'b0 : skid_v_q ? !drain : load_skid;
    main_n   = load_in ? in_ent : load_sk ? skid_q : main_q;
    // an empty main slot is a bubble: its control bits are forced to zero
    main_d   = {main_v_d ? main_n[EW-1:LW] : {(WB_W+M_W){1'b0}}, main_n[LW-1:0]};
    skid_d   = load_skid ? in_ent : skid_q;
    occ_d    = {1'b0, main_v_d} + {1'b0, skid_v_d};
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
      occ_q    <= 2'd0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
      occ_q    <= occ_d;
    end
  end
  assign in_ready_o  = rdy_q;
  assign out_valid_o = main_v_q;
  assign occ_o       = occ_q;
  assign {WB_o, M_o, ALU_o, wdata_o, rd_o} = main_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue model.
module tb_pipe_stage_skid;
  localparam int DW = 64;
  localparam int RW = 6;
  typedef struct packed {
    logic [1:0]    wb;
    logic [1:0]    m;
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [RW-1:0] rd;
  } ent_t;
  logic          clk = 0, rst_n = 0, flush = 0, iv = 0, ordy = 0;
  logic [1:0]    wb_i = 0, m_i = 0;
  logic [DW-1:0] alu_i = 0, wd_i = 0;
  logic [RW-1:0] rd_i = 0;
  logic          irdy, ov;
  logic [1:0]    wb_o, m_o, occ;
  logic [DW-1:0] alu_o, wd_o;
  logic [RW-1:0] rd_o;
  int vec = 0, miss = 0;
  ent_t q[$];
  ent_t shown;
  always #5 clk = ~clk;
  pipe_stage_skid #(.WB_W(2), .M_W(2), .DATA_W(DW), .REG_W(RW)) dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .in_valid_i(iv), .in_ready_o(irdy),
    .WB_i(wb_i), .M_i(m_i), .ALU_i(alu_i), .wdata_i(wd_i), .rd_i(rd_i),
    .out_valid_o(ov), .out_ready_i(ordy), .WB_o(wb_o), .M_o(m_o), .ALU_o(alu_o),
    .wdata_o(wd_o), .rd_o(rd_o), .occ_o(occ)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // model: the stage is a FIFO of depth 2; the head is what the outputs show
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      shown = '0;
    end else begin
      automatic bit acc = iv && (q.size() < 2);
      automatic bit drn = ordy && (q.size() > 0);
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back('{wb_i, m_i, alu_i, wd_i, rd_i});
      end
      if (q.size() > 0) shown = q[0];
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", ov, q.size() > 0);
      chk("in_ready", irdy, q.size() < 2);
      chk("occ", occ, q.size());
      chk("WB", wb_o, q.size() > 0 ? shown.wb : 2'b0);
      chk("M", m_o, q.size() > 0 ? shown.m : 2'b0);
      chk("ALU", alu_o, shown.alu);
      chk("wdata", wd_o, shown.wd);
      chk("rd", rd_o, shown.rd);
    end
  end
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic put(input logic v, input logic [1:0] w, input logic [1:0] m, input logic [63:0] a);
    iv = v; wb_i = w; m_i = m; alu_i = a; wd_i = a ^ 64'h5555; rd_i = a[RW-1:0];
  endtask
  initial begin
    repeat (2) tick();
    chk("rst occ", occ, 0);
    chk("rst in_ready", irdy, 1);
    chk("rst out_valid", ov, 0);
    chk("rst ALU", alu_o, 0);
    rst_n = 1;
    ordy = 1;
    put(1, 2'b11, 2'b01, 64'h10);
    tick();
    chk("first valid", ov, 1);
    chk("first ALU", alu_o, 64'h10);
    chk("first WB", wb_o, 2'b11);
    chk("first M", m_o, 2'b01);
    chk("first occ", occ, 1);
    for (int i = 1; i <= 4; i++) begin
      put(1, 2'b10, 2'b00, 64'(i));
      tick();
      chk("stream ALU", alu_o, 64'(i));
      chk("stream in_ready", irdy, 1);
    end
    put(0, 0, 0, 0);
    tick();
    chk("drain valid", ov, 0);
    chk("drain WB", wb_o, 0);
    chk("drain ALU hold", alu_o, 64'h4);
    ordy = 0;
    put(1, 2'b01, 2'b10, 64'hA);
    tick();
    put(1, 2'b11, 2'b11, 64'hB);
    tick();
    put(0, 0, 0, 0);
    chk("stall occ", occ, 2);
    chk("stall in_ready", irdy, 0);
    chk("stall ALU", alu_o, 64'hA);
    tick();
    chk("stall hold ALU", alu_o, 64'hA);
    chk("stall hold M", m_o, 2'b10);
    ordy = 1;
    tick();
    chk("unstall ALU", alu_o, 64'hB);
    chk("unstall occ", occ, 1);
    tick();
    chk("empty valid", ov, 0);
    chk("empty WB", wb_o, 0);
    chk("empty M", m_o, 0);
    ordy = 0;
    put(1, 2'b11, 2'b11, 64'hD);
    tick();
    put(1, 2'b11, 2'b11, 64'hE);
    tick();
    chk("pre-flush occ", occ, 2);
    flush = 1;
    put(1, 2'b11, 2'b11, 64'hC);
    tick();
    flush = 0;
    put(0, 0, 0, 0);
    chk("flush occ", occ, 0);
    chk("flush valid", ov, 0);
    chk("flush WB", wb_o, 0);
    chk("flush M", m_o, 0);
    chk("flush in_ready", irdy, 1);
    ordy = 1;
    repeat (2) tick();
    chk("C dropped", ov, 0);
    put(1, 2'b11, 2'b10, 64'hF0);
    tick();
    put(0, 0, 0, 0);
    chk("pre-rst occ", occ, 1);
    #2 rst_n = 0;
    #1;
    chk("arst WB", wb_o, 0);
    chk("arst M", m_o, 0);
    chk("arst ALU", alu_o, 0);
    chk("arst valid", ov, 0);
    chk("arst in_ready", irdy, 1);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!(iv && !irdy)) put($urandom_range(0, 1), 2'($urandom), 2'($urandom), {$urandom, $urandom});
      ordy = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 40) == 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
